// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, divide op encodings and the divider FSM states.
package rv32m_pkg;

    localparam int XLEN = 32;

    // op[0] selects unsigned, op[1] selects remainder
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;

    // One guard bit above the partial remainder makes the trial sign explicit
    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign trial   = shifted - {2'b00, divisor_i};

    always_comb begin
        if (!trial[XLEN+1]) begin
            rem_o = trial[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer: stalls EX for 34 cycles (1 for
// divide-by-zero and signed overflow) and presents the result with a done pulse.
module div_seq
    import rv32m_pkg::*;
#(
    parameter int XLEN = rv32m_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST   = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_SI = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;
    logic            is_rem_q, is_rem_d, sgn_q, sgn_d;

    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic            is_signed;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign is_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        is_rem_d = is_rem_q;
        sgn_d    = sgn_q;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (rs2 == '0) begin
                        result_d = op[1] ? rs1 : '1;
                        state_d  = DONE;
                    end else if (is_signed && rs1 == MIN_SI && rs2 == '1) begin
                        result_d = op[1] ? '0 : MIN_SI;
                        state_d  = DONE;
                    end else begin
                        quo_d    = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
                        dvs_d    = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;
                        qneg_d   = rs1[XLEN-1] ^ rs2[XLEN-1];
                        rneg_d   = rs1[XLEN-1];
                        is_rem_d = op[1];
                        sgn_d    = is_signed;
                        rem_d    = '0;
                        cnt_d    = '0;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                if (is_rem_q)
                    result_d = (sgn_q && rneg_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
                else
                    result_d = (sgn_q && qneg_q) ? -quo_q : quo_q;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // An aborted instruction must leave the previously delivered result intact
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_rem_q <= 1'b0;
            sgn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            is_rem_q <= is_rem_d;
            sgn_q    <= sgn_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC) || (state_q == FIX);
    assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed bench for div_seq against an arithmetic RV32M reference.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic        flush;
    logic        busy, stall, done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res = '0;

    div_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            2'b10: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op with start held until done; optionally scramble the request mid-CALC.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit scramble);
        logic [31:0] exp_res;
        int exp_lat, cyc;
        bit stall_ok;
        exp_res = model(o, a, b);
        exp_lat = model_lat(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL start_stall op=%0d got=%b want=1", o, stall);
        end
        cyc = 0;
        stall_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (!done && stall !== 1'b1) stall_ok = 1'b0;
            if (scramble && cyc == 5) begin
                op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
            end
        end while (!done && cyc < 100);
        total++;
        if (cyc !== exp_lat) begin
            bad++; $display("FAIL latency op=%0d a=%h b=%h got=%0d want=%0d", o, a, b, cyc, exp_lat);
        end
        total++;
        if (result !== exp_res) begin
            bad++; $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", o, a, b, result, exp_res);
        end
        total++;
        if (!stall_ok || stall !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL stall_busy op=%0d ok=%b stall=%b busy=%b want ok=1 stall=0 busy=1", o, stall_ok, stall, busy);
        end
        start = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL back_idle done=%b busy=%b want 0 0", done, busy);
        end
        last_res = exp_res;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'h0) begin
            bad++; $display("FAIL reset busy=%b done=%b stall=%b result=%h want 0", busy, done, stall, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        do_op(2'b01, 32'd100, 32'd7, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op(2'b11, 32'd5, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_signed();
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_op(2'b00, 32'h8000_0000, 32'd1, 1'b0);
    endtask

    task automatic test_special();
        do_op(2'b00, 32'd5, 32'd0, 1'b0);
        do_op(2'b10, 32'd5, 32'd0, 1'b0);
        do_op(2'b01, 32'd9, 32'd0, 1'b0);
        do_op(2'b11, 32'd9, 32'd0, 1'b0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_ignore_restart();
        do_op(2'b01, 32'd100, 32'd7, 1'b1);
        do_op(2'b10, 32'hFFFF_FF00, 32'd10, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 6 == 1) b = b >> $urandom_range(31, 16);
            if (i % 8 == 3) b = 32'h0;
            if (i % 8 == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            do_op(2'($urandom), a, b, 1'b0);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prior;
        bit seen;
        prior = last_res;
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1 = $urandom; rs2 = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== prior) begin
            bad++; $display("FAIL flush_calc busy=%b done=%b result=%h want 0 0 %h", busy, done, result, prior);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL flush_no_done got=%b want=0", seen);
        end
        start = 1'b1; flush = 1'b1; op = 2'b00; rs1 = 32'd5; rs2 = 32'd0;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL flush_start_stall got=%b want=0", stall);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== prior) begin
            bad++; $display("FAIL flush_wins busy=%b done=%b result=%h want 0 0 %h", busy, done, result, prior);
        end
        start = 1'b0; flush = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd7;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0; start = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            bad++; $display("FAIL async_reset busy=%b stall=%b done=%b result=%h want 0", busy, stall, done, result);
        end
        #1;
        rst_n = 1'b1;
        do_op(2'b01, 32'd9, 32'd3, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_op(2'b11, 32'd1234567, 32'd1000, 1'b0);
        do_op(2'b10, 32'd5, 32'd0, 1'b0);
        do_op(2'b00, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_ignore_restart();
        test_flush();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU) in the EX stage. It accepts one operation at a time and runs a 32-iteration restoring shift-subtract loop. It holds the pipeline with `stall` until the signed-corrected result is ready, then presents it with a one-cycle `done` pulse. The EX-stage result mux takes `result` as one of its inputs.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; the iteration count equals `XLEN`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request from EX; sampled only in IDLE.
- `op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1`  in  XLEN  dividend.
- `rs2`  in  XLEN  divisor.
- `flush`  in  1  synchronous abort from the hazard unit.
- `busy`  out  1  high in CALC, FIX and DONE.
- `stall`  out  1  combinational: (IDLE & `start` & ~`flush`) | CALC | FIX.
- `done`  out  1  high exactly in the DONE state.
- `result`  out  XLEN  registered quotient or remainder; holds its value until the next completion.

## Operation
- States:
  - IDLE.
  - CALC: 32 iterations, tracked by a 5-bit counter.
  - FIX: sign correction.
  - DONE: one cycle, result valid.
- IDLE with `start` high:
  - Divisor zero: load `result` directly. DIV/DIVU give all-ones. REM/REMU give `rs1`. Go to DONE.
  - Signed overflow (DIV or REM, `rs1`=0x80000000, `rs2`=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0. Go to DONE.
  - Otherwise:
    - Latch the magnitudes of `rs1` and `rs2`; use two's-complement absolute value for signed ops, raw values for unsigned.
    - Latch quotient sign = sign(rs1) XOR sign(rs2), remainder sign = sign(rs1), and the op type.
    - Clear the partial remainder (XLEN+1 bits) and the counter. Go to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left by one.
  - Compute trial = rem − divisor. If it is non-negative, rem takes trial and the quotient LSB is 1. Otherwise the quotient LSB is 0.
  - The counter increments. When counter=31, go to FIX.
- FIX:
  - Select the quotient or the remainder according to the latched op.
  - Negate it if the corresponding latched sign is set and the op is signed.
  - Write it to `result`. Go to DONE.
- DONE: go to IDLE unconditionally. `start` is never sampled in DONE.
- `start` outside IDLE is ignored. The pipeline must keep the request asserted until `done`; it drops the request once the instruction advances.
- `flush` in any state: go to IDLE at the next edge with no `done` pulse and `result` unchanged. `flush` wins over a simultaneous `start`.
- Reset, including mid-operation:
  - State IDLE, counter 0, `result` 0, internal registers 0.
  - `busy`=0, `done`=0, `stall`=0.

## Timing
- `start` is accepted at edge E.
- Normal path:
  - CALC spans edges E+1..E+32.
  - FIX is the cycle after E+32; `result` is written at E+33.
  - `done`=1 from E+33 to E+34: a 34-cycle latency.
- Special case: `result` is written at E and `done`=1 from E to E+1: a 1-cycle latency.
- `stall` drops in DONE, so the EX instruction captures `result` on the edge that ends DONE.
- A back-to-back `start` is accepted no earlier than the first IDLE cycle after DONE.

## Structure
- Shared package `rv32m_pkg`:
  - op encodings `DIV_OP_DIV/DIVU/REM/REMU`;
  - the state enum `div_state_t` {IDLE, CALC, FIX, DONE};
  - `XLEN`.
- One sub-module, `div_step`: a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- The FSM, counter and sign logic remain in `div_seq`.

## Test plan
- DIVU 100/7: `done` at cycle 34 after `start`, `result`=14; repeat with REMU → 2.
- DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); REM 7/−2 → 1.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `done` one cycle after `start` and `stall` high for only the `start` cycle.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0; 1-cycle latency.
- `flush` in CALC cycle 10 → IDLE next edge, no `done`, `result` keeps the prior value. A new `start` changing `op`, `rs1` or `rs2` mid-CALC has no effect.
- `rst_n` low for a fraction of a cycle mid-CALC → immediately `busy`=0, `stall`=0, `result`=0. After release, a DIVU 9/3 completes normally with `result`=3.
